ascon_job_arbiter: RTL and testbench

- Shares one ASCON controller (start_enc/start_dec, 32-bit data_in stream, data_out stream, busy/done/auth) between NumReq independent requesters, e.g. the CPU OBI port and DMA channels.
- Round-robin grant per job; the owner keeps the core until done, then the core is released.
- Sits between the requester-side stream ports and the ASCON controller inputs/outputs, replacing direct register-driven start/data signals.

---
 rtl/ascon_job_arbiter.sv | 157 +++++++++++++++
 tb/tb_ascon_job_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_job_arbiter.sv
// rtl/ascon_job_arbiter.sv - round-robin job arbiter sharing one ASCON core between NumReq requesters
// Optional watchdog abort is enabled by defining ASCON_ARB_WDOG_EN.
module ascon_job_arbiter #(
    parameter int NumReq        = 2,
    parameter int IdxW          = $clog2(NumReq),
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumReq-1:0]    req_valid_i,
    input  logic [NumReq-1:0]    req_dec_i,
    output logic [NumReq-1:0]    gnt_o,
    input  logic [NumReq-1:0]    word_valid_i,
    input  logic [NumReq*32-1:0] word_i,
    output logic [NumReq-1:0]    word_ready_o,
    output logic [NumReq-1:0]    rsp_valid_o,
    output logic [31:0]          rsp_data_o,
    output logic [NumReq-1:0]    done_o,
    output logic [NumReq-1:0]    auth_o,
    output logic [NumReq-1:0]    err_o,
    output logic                 busy_o,
    output logic [IdxW-1:0]      owner_o,
    output logic                 core_start_enc_o,
    output logic                 core_start_dec_o,
    output logic                 core_abort_o,
    output logic [31:0]          core_data_o,
    output logic                 core_data_valid_o,
    input  logic [31:0]          core_data_out_i,
    input  logic                 core_data_out_valid_i,
    input  logic                 core_busy_i,
    input  logic                 core_done_i,
    input  logic                 core_auth_i
);

    if (NumReq < 2 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_param_check
        $error("ascon_job_arbiter: illegal NumReq or TimeoutCycles");
    end

    typedef enum logic [2:0] {IDLE, GRANT, START, RUN, RELEASE} state_t;

    state_t              r_state;
    logic [IdxW-1:0]     r_owner;
    logic [IdxW-1:0]     r_ptr;
    logic                r_dec;
    logic [NumReq-1:0]   r_gnt;
    logic                r_start_enc;
    logic                r_start_dec;

    logic                w_found;
    logic [IdxW-1:0]     w_pick;
    logic [NumReq-1:0]   w_pick_oh;
    logic [NumReq-1:0]   w_owner_oh;
    logic                w_run;
    logic                w_done;
    logic                w_expire;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NumReq; k++) begin
            if (!w_found && req_valid_i[(int'(r_ptr) + k) % NumReq]) begin
                w_found = 1'b1;
                w_pick  = IdxW'((int'(r_ptr) + k) % NumReq);
            end
        end
    end

    assign w_pick_oh  = NumReq'(1) << w_pick;
    assign w_owner_oh = NumReq'(1) << r_owner;
    assign w_run      = (r_state == RUN);
    assign w_done     = w_run && core_done_i;

`ifdef ASCON_ARB_WDOG_EN
    localparam logic [15:0] WdogLast = 16'(TimeoutCycles - 1);
    logic [15:0] r_wdog;
    // Done in the expiry cycle takes priority over the abort.
    assign w_expire = w_run && !core_done_i && !core_data_out_valid_i && (r_wdog == WdogLast);
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_ptr       <= IdxW'(NumReq - 1);
            r_dec       <= 1'b0;
            r_gnt       <= '0;
            r_start_enc <= 1'b0;
            r_start_dec <= 1'b0;
`ifdef ASCON_ARB_WDOG_EN
            r_wdog      <= '0;
`endif
        end else begin
            r_gnt       <= '0;
            r_start_enc <= 1'b0;
            r_start_dec <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_ptr   <= w_pick;
                        r_dec   <= req_dec_i[w_pick];
                        r_gnt   <= w_pick_oh;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_start_enc <= !r_dec;
                    r_start_dec <= r_dec;
                    r_state     <= START;
                end
                START: begin
                    r_state <= RUN;
`ifdef ASCON_ARB_WDOG_EN
                    r_wdog  <= '0;
`endif
                end
                RUN: begin
                    if (core_done_i || w_expire) begin
                        r_state <= RELEASE;
                    end
`ifdef ASCON_ARB_WDOG_EN
                    if (core_data_out_valid_i) begin
                        r_wdog <= '0;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    if (!core_busy_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_o             = r_gnt;
    assign busy_o            = (r_state != IDLE);
    assign owner_o           = r_owner;
    assign core_start_enc_o  = r_start_enc;
    assign core_start_dec_o  = r_start_dec;
    assign word_ready_o      = w_run ? w_owner_oh : '0;
    assign core_data_valid_o = w_run && word_valid_i[r_owner];
    assign core_data_o       = w_run ? word_i[32*int'(r_owner) +: 32] : 32'h0;
    assign rsp_valid_o       = (w_run && core_data_out_valid_i) ? w_owner_oh : '0;
    assign rsp_data_o        = (w_run && core_data_out_valid_i) ? core_data_out_i : 32'h0;
    assign done_o            = w_done ? w_owner_oh : '0;
    assign auth_o            = (w_done && core_auth_i) ? w_owner_oh : '0;
    assign err_o             = w_expire ? w_owner_oh : '0;
    assign core_abort_o      = w_expire;

endmodule

// File: tb/tb_ascon_job_arbiter.sv
// tb/tb_ascon_job_arbiter.sv - self-checking bench for ascon_job_arbiter
module tb_ascon_job_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req_valid_i = '0, req_dec_i = '0, word_valid_i = '0;
    logic [63:0] word_i = '0;
    logic [31:0] core_data_out_i = '0;
    logic        core_data_out_valid_i = 1'b0, core_busy_i = 1'b0;
    logic        core_done_i = 1'b0, core_auth_i = 1'b0;

    logic [1:0]  gnt_o, word_ready_o, rsp_valid_o, done_o, auth_o, err_o;
    logic [31:0] rsp_data_o, core_data_o;
    logic        busy_o, core_start_enc_o, core_start_dec_o, core_abort_o, core_data_valid_o;
    logic [0:0]  owner_o;

    ascon_job_arbiter #(.NumReq(2), .TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_dec_i(req_dec_i), .gnt_o(gnt_o),
        .word_valid_i(word_valid_i), .word_i(word_i), .word_ready_o(word_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .done_o(done_o), .auth_o(auth_o), .err_o(err_o),
        .busy_o(busy_o), .owner_o(owner_o),
        .core_start_enc_o(core_start_enc_o), .core_start_dec_o(core_start_dec_o),
        .core_abort_o(core_abort_o), .core_data_o(core_data_o),
        .core_data_valid_o(core_data_valid_o),
        .core_data_out_i(core_data_out_i), .core_data_out_valid_i(core_data_out_valid_i),
        .core_busy_i(core_busy_i), .core_done_i(core_done_i), .core_auth_i(core_auth_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [1:0]  wv;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        ov;
        logic [31:0] od;
        logic        dv;
        logic [1:0]  rdy;
        logic [1:0]  rv;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_gnt"}, 32'(gnt_o), 32'h0);
        check({name, "_busy"}, 32'(busy_o), 32'h0);
        check({name, "_owner"}, 32'(owner_o), 32'h0);
        check({name, "_ready"}, 32'(word_ready_o), 32'h0);
        check({name, "_rsp"}, {rsp_data_o[29:0], rsp_valid_o}, 32'h0);
        check({name, "_done"}, {26'h0, done_o, auth_o, err_o}, 32'h0);
        check({name, "_core"}, {core_data_o[27:0], core_start_enc_o, core_start_dec_o,
                                core_abort_o, core_data_valid_o}, 32'h0);
    endtask

    task automatic sb_check(input string name);
        if (core_data_valid_o) begin
            if (sb_q.size() == 0) begin
                check({name, "_unexpected_word"}, core_data_o, 32'hxxxxxxxx);
            end else begin
                check(name, core_data_o, sb_q.pop_front());
            end
        end
    endtask

    // Waits for a grant (bounded), checks it and the start pulse; leaves the bench in RUN.
    task automatic to_run(input logic [1:0] exp_gnt, input logic exp_dec);
        int n = 0;
        while (gnt_o == 2'b00 && n < 10) begin
            @(negedge clk_i); #1;
            n++;
        end
        check("gnt", 32'(gnt_o), 32'(exp_gnt));
        check("gnt_onehot", 32'($countones(gnt_o)), 32'd1);
        @(negedge clk_i); #1;
        check("start_enc", 32'(core_start_enc_o), 32'(!exp_dec));
        check("start_dec", 32'(core_start_dec_o), 32'(exp_dec));
        check("gnt_pulse", 32'(gnt_o), 32'h0);
        @(negedge clk_i); #1;
        check("ready_run", 32'(word_ready_o), 32'(exp_gnt));
    endtask

    task automatic finish_job(input logic [1:0] exp_oh);
        core_done_i = 1'b1; core_auth_i = 1'b0; core_busy_i = 1'b0;
        #1;
        check("job_done", 32'(done_o), 32'(exp_oh));
        check("job_auth", 32'(auth_o), 32'h0);
        @(negedge clk_i);
        core_done_i = 1'b0;
        @(negedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vt[0] = '{2'b01, 32'hA0000001, 32'h0,        1'b0, 32'h0,        1'b1, 2'b01, 2'b00};
        vt[1] = '{2'b10, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2'b01, 2'b00};
        vt[2] = '{2'b11, 32'hA0000002, 32'hB0000002, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00};
        vt[3] = '{2'b00, 32'h0,        32'h0,        1'b1, 32'hC0FFEE00, 1'b0, 2'b01, 2'b01};
        vt[4] = '{2'b01, 32'hA0000003, 32'h0,        1'b1, 32'h11110000, 1'b1, 2'b01, 2'b01};
        vt[5] = '{2'b01, 32'hA0000004, 32'h0,        1'b0, 32'h0,        1'b1, 2'b01, 2'b00};

        repeat (3) @(negedge clk_i);
        #1;
        check_all_zero("reset");
        rst_ni = 1'b1;

        // Job 1: requester 0 encrypts
        @(negedge clk_i);
        core_done_i = 1'b1;
        #1;
        check("done_idle_ignored", 32'(done_o), 32'h0);
        core_done_i = 1'b0;
        req_valid_i = 2'b01; req_dec_i = 2'b00;
        @(negedge clk_i); #1;
        req_valid_i = 2'b00;
        core_busy_i = 1'b1;
        to_run(2'b01, 1'b0);
        for (int i = 0; i < 6; i++) begin
            word_valid_i = vt[i].wv;
            word_i = {vt[i].w1, vt[i].w0};
            core_data_out_valid_i = vt[i].ov;
            core_data_out_i = vt[i].od;
            if (vt[i].wv[0]) sb_q.push_back(vt[i].w0);
            #1;
            check($sformatf("vec%0d_dv", i), 32'(core_data_valid_o), 32'(vt[i].dv));
            check($sformatf("vec%0d_ready", i), 32'(word_ready_o), 32'(vt[i].rdy));
            check($sformatf("vec%0d_rv", i), 32'(rsp_valid_o), 32'(vt[i].rv));
            if (vt[i].rv != 2'b00) check($sformatf("vec%0d_rd", i), rsp_data_o, vt[i].od);
            sb_check($sformatf("vec%0d_word", i));
            @(negedge clk_i);
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        word_valid_i = '0; core_data_out_valid_i = 1'b0;
        core_done_i = 1'b1; core_auth_i = 1'b1;
        #1;
        check("job1_done", 32'(done_o), 32'h1);
        check("job1_auth", 32'(auth_o), 32'h1);
        @(negedge clk_i);
        core_done_i = 1'b0; core_auth_i = 1'b0;
        #1;
        check("release_busy", 32'(busy_o), 32'h1);
        check("release_no_done", 32'(done_o), 32'h0);
        @(negedge clk_i); #1;
        check("release_hold", 32'(busy_o), 32'h1);
        core_busy_i = 1'b0;
        @(negedge clk_i); #1;
        check("idle_busy", 32'(busy_o), 32'h0);

        // Job 2: requester 1 decrypts, requester 0 words are ignored
        req_valid_i = 2'b10; req_dec_i = 2'b10;
        @(negedge clk_i); #1;
        req_valid_i = 2'b00; core_busy_i = 1'b1;
        to_run(2'b10, 1'b1);
        check("owner1", 32'(owner_o), 32'h1);
        word_valid_i = 2'b01; word_i = {32'h0, 32'hDEADBEEF};
        #1;
        check("nonowner_dv", 32'(core_data_valid_o), 32'h0);
        check("nonowner_ready", 32'(word_ready_o), 32'h2);
        sb_check("nonowner_word");
        @(negedge clk_i);
        word_valid_i = 2'b10; word_i = {32'h12340001, 32'hDEADBEEF};
        sb_q.push_back(32'h12340001);
        #1;
        sb_check("owner1_word");
        check("owner1_sb_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk_i);
        word_valid_i = 2'b00;
        core_data_out_valid_i = 1'b1; core_data_out_i = 32'h12345678;
        core_done_i = 1'b1; core_auth_i = 1'b1;
        #1;
        check("same_rv", 32'(rsp_valid_o), 32'h2);
        check("same_rd", rsp_data_o, 32'h12345678);
        check("same_done", 32'(done_o), 32'h2);
        check("same_auth", 32'(auth_o), 32'h2);
        @(negedge clk_i);
        core_data_out_valid_i = 1'b0; core_done_i = 1'b0; core_auth_i = 1'b0; core_busy_i = 1'b0;
        @(negedge clk_i); #1;
        check("job2_idle", 32'(busy_o), 32'h0);

        // Reset in the middle of a job
        req_valid_i = 2'b10; req_dec_i = 2'b00;
        @(negedge clk_i); #1;
        req_valid_i = 2'b00; core_busy_i = 1'b1;
        to_run(2'b10, 1'b0);
        word_valid_i = 2'b10; core_data_out_valid_i = 1'b1; core_data_out_i = 32'hFFFF0000;
        #1;
        check("prereset_rv", 32'(rsp_valid_o), 32'h2);
        rst_ni = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        @(negedge clk_i);
        word_valid_i = '0; core_data_out_valid_i = 1'b0; core_busy_i = 1'b0;
        #1;
        check("reset_no_done", {30'h0, done_o | err_o}, 32'h0);
        rst_ni = 1'b1;

        // Fairness: both requesting continuously
        @(negedge clk_i);
        req_valid_i = 2'b11; req_dec_i = 2'b10;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_i); #1;
            to_run((j % 2 == 0) ? 2'b01 : 2'b10, (j % 2 == 1));
            finish_job((j % 2 == 0) ? 2'b01 : 2'b10);
        end
        req_valid_i = 2'b00;
        @(negedge clk_i); @(negedge clk_i); #1;
        check("fair_idle", 32'(busy_o), 32'h0);

        // Silent core: watchdog behaviour
        req_valid_i = 2'b01; req_dec_i = 2'b00;
        @(negedge clk_i); #1;
        req_valid_i = 2'b00; core_busy_i = 1'b1;
        to_run(2'b01, 1'b0);
`ifdef ASCON_ARB_WDOG_EN
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("wdog_err_c%0d", k), 32'(err_o), (k == 16) ? 32'h1 : 32'h0);
            check($sformatf("wdog_abort_c%0d", k), 32'(core_abort_o), (k == 16) ? 32'h1 : 32'h0);
            check($sformatf("wdog_done_c%0d", k), 32'(done_o), 32'h0);
            @(negedge clk_i); #1;
        end
        check("wdog_release", 32'(word_ready_o), 32'h0);
        check("wdog_err_pulse", 32'(err_o), 32'h0);
        core_busy_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i); #1;
        check("wdog_idle", 32'(busy_o), 32'h0);
`else
        for (int k = 1; k <= 20; k++) begin
            check($sformatf("nowdog_err_c%0d", k), {30'h0, err_o[0], core_abort_o}, 32'h0);
            @(negedge clk_i); #1;
        end
        check("nowdog_still_run", 32'(word_ready_o), 32'h1);
        check("nowdog_busy", 32'(busy_o), 32'h1);
        finish_job(2'b01);
        check("nowdog_idle", 32'(busy_o), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
